// File: rtl/mm2s_packet_router.sv
// MM2S AXI Stream router: steers whole packets to per-channel FIFOs by tdest,
// drops packets to nonexistent channels, and keeps debug counters and error flags.
module mm2s_packet_router #(
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int FIFO_DATA_WIDTH = 32,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int AXIS_DEST_WIDTH = 4,
    parameter int NUM_CHANNELS    = 2,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                              clk_in,
    input  logic                              rst_n_in,
    input  logic [AXIS_DATA_WIDTH-1:0]        SRC_AXIS_tdata_in,
    input  logic [AXIS_DEST_WIDTH-1:0]        SRC_AXIS_tdest_in,
    input  logic [AXIS_KEEP_WIDTH-1:0]        SRC_AXIS_tkeep_in,
    input  logic                              SRC_AXIS_tlast_in,
    input  logic                              SRC_AXIS_tuser_in,
    input  logic                              SRC_AXIS_tvalid_in,
    output logic                              SRC_AXIS_tready_out,
    output logic [FIFO_DATA_WIDTH-1:0]        fifo_data_out,
    output logic                              fifo_last_out,
    output logic [NUM_CHANNELS-1:0]           fifo_w_stb_out,
    input  logic [NUM_CHANNELS-1:0]           fifo_full_in,
    output logic [NUM_CHANNELS*CNT_WIDTH-1:0] pkt_count_out,
    output logic [CNT_WIDTH-1:0]              drop_count_out,
    output logic                              err_tdest_out,
    output logic                              err_keep_out,
    input  logic                              err_clr_in
);

    typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;

    state_t                     state_q, state_d;
    logic [AXIS_DEST_WIDTH-1:0] ch_q, ch_d;
    logic [CNT_WIDTH-1:0]       pkt_cnt_q [NUM_CHANNELS];
    logic [CNT_WIDTH-1:0]       pkt_cnt_d [NUM_CHANNELS];
    logic [CNT_WIDTH-1:0]       drop_cnt_q, drop_cnt_d;
    logic                       err_tdest_q, err_tdest_d;
    logic                       err_keep_q, err_keep_d;

    logic [AXIS_DEST_WIDTH-1:0] tgt;
    logic                       dest_ok;
    logic                       routing;
    logic                       tgt_full;
    logic                       tready;
    logic                       beat;
    logic                       unused_tuser;

    assign unused_tuser = SRC_AXIS_tuser_in;

    // Only the target FIFO's full flag is ever consulted, so an idle full
    // channel never stalls traffic headed elsewhere.
    always_comb begin
        dest_ok  = 32'(SRC_AXIS_tdest_in) < NUM_CHANNELS;
        tgt      = (state_q == IDLE) ? SRC_AXIS_tdest_in : ch_q;
        routing  = (state_q == ROUTE) || ((state_q == IDLE) && dest_ok);
        tgt_full = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (tgt == AXIS_DEST_WIDTH'(i)) tgt_full = fifo_full_in[i];
        end
        tready = routing ? !tgt_full : 1'b1;
        beat   = SRC_AXIS_tvalid_in && tready;
        fifo_w_stb_out = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            fifo_w_stb_out[i] = beat && routing && (tgt == AXIS_DEST_WIDTH'(i));
        end
    end

    assign SRC_AXIS_tready_out = tready;
    assign fifo_data_out       = SRC_AXIS_tdata_in;
    assign fifo_last_out       = SRC_AXIS_tlast_in;

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        pkt_cnt_d   = pkt_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        err_tdest_d = err_tdest_q;
        err_keep_d  = err_keep_q;

        unique case (state_q)
            IDLE: begin
                if (beat && dest_ok) ch_d = SRC_AXIS_tdest_in;
                if (beat && !SRC_AXIS_tlast_in) state_d = dest_ok ? ROUTE : DROP;
            end
            ROUTE, DROP: begin
                if (beat && SRC_AXIS_tlast_in) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (beat && SRC_AXIS_tlast_in && routing && (tgt == AXIS_DEST_WIDTH'(i)))
                pkt_cnt_d[i] = pkt_cnt_q[i] + 1'b1;
        end
        if (beat && SRC_AXIS_tlast_in && !routing)
            drop_cnt_d = drop_cnt_q + 1'b1;

        // Clear first so a same-cycle error event wins.
        if (err_clr_in) begin
            err_tdest_d = 1'b0;
            err_keep_d  = 1'b0;
        end
        if (beat && (state_q == ROUTE) && (SRC_AXIS_tdest_in != ch_q))
            err_tdest_d = 1'b1;
        if (beat && !SRC_AXIS_tlast_in && !(&SRC_AXIS_tkeep_in))
            err_keep_d = 1'b1;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            drop_cnt_q  <= '0;
            err_tdest_q <= 1'b0;
            err_keep_q  <= 1'b0;
            for (int i = 0; i < NUM_CHANNELS; i++) pkt_cnt_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            drop_cnt_q  <= drop_cnt_d;
            err_tdest_q <= err_tdest_d;
            err_keep_q  <= err_keep_d;
            for (int i = 0; i < NUM_CHANNELS; i++) pkt_cnt_q[i] <= pkt_cnt_d[i];
        end
    end

    always_comb begin
        pkt_count_out = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            pkt_count_out[i*CNT_WIDTH +: CNT_WIDTH] = pkt_cnt_q[i];
        end
    end

    assign drop_count_out = drop_cnt_q;
    assign err_tdest_out  = err_tdest_q;
    assign err_keep_out   = err_keep_q;

endmodule
